adrv9001_rx_word_aligner: RTL

Parametrised receive word aligner for the ADRV9001 LVDS/CMOS SSI path: it detects the strobe bit phase, qualifies it through a lock state machine, and bit-shifts `CHANNELS` parallel deserialised lanes onto the strobe word boundary. It sits between the per-lane serdes deserialisers and the RX sample unpacker, one instance per RX port. It succeeds the fixed 16-bit I/Q aligner. It adds generic width and channel count, runtime strobe mode, lock/loss qualification and a resync control.

---
 rtl/adrv9001_pkg.sv | 15 +
 rtl/adrv9001_strb_phase_detect.sv | 51 +++++
 rtl/adrv9001_rx_word_aligner.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/adrv9001_pkg.sv
// Shared types and constants for the ADRV9001 RX word aligner.
package adrv9001_pkg;

    // Lock qualification states
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Strobe formats selected by strb_mode
    localparam logic STRB_PULSE = 1'b0;
    localparam logic STRB_HALF  = 1'b1;

endpackage

// File: rtl/adrv9001_strb_phase_detect.sv
// Strobe hold register and candidate phase search.
// The window is {previous strobe word, current strobe word}; the slice for
// phase p is window[2W-1-p -: W]. The lowest matching p wins.
module adrv9001_strb_phase_detect
    import adrv9001_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic                     strb_mode,
    input  logic [WIDTH-1:0]         strb_in,
    output logic                     match,
    output logic [$clog2(WIDTH)-1:0] cand_phase
);

    localparam int PW = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] PAT_PULSE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] PAT_HALF  = {{(WIDTH/2){1'b1}}, {(WIDTH/2){1'b0}}};

    logic [WIDTH-1:0]   strb_hold;
    logic [2*WIDTH-1:0] window;
    logic [WIDTH-1:0]   pattern;

    // Previous strobe word, loaded only on qualified input cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_hold <= '0;
        end else if (valid_in) begin
            strb_hold <= strb_in;
        end
    end

    assign window  = {strb_hold, strb_in};
    assign pattern = (strb_mode == STRB_HALF) ? PAT_HALF : PAT_PULSE;

    // Scan from the highest phase down so the lowest match is the one kept
    always_comb begin
        match      = 1'b0;
        cand_phase = '0;
        for (int p = WIDTH - 1; p >= 0; p--) begin
            if (WIDTH'(window >> (WIDTH - p)) == pattern) begin
                match      = 1'b1;
                cand_phase = PW'(p);
            end
        end
    end

endmodule

// File: rtl/adrv9001_rx_word_aligner.sv
// ADRV9001 SSI receive word aligner: strobe phase lock state machine plus
// per-lane barrel shifters that place each lane on the strobe word boundary.
module adrv9001_rx_word_aligner
    import adrv9001_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CHANNELS     = 2,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      strb_mode,
    input  logic                      resync,
    input  logic [WIDTH-1:0]          strb_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      valid_in,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic                      valid_out,
    output logic                      locked,
    output logic [$clog2(WIDTH)-1:0]  phase,
    output logic                      lock_lost
);

    localparam int PW        = $clog2(WIDTH);
    localparam int CNT_LIMIT = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int CW        = $clog2(CNT_LIMIT + 1);

    localparam logic [CW-1:0] CNT_MAX     = CW'(CNT_LIMIT);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_COUNT - 1);
    localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_COUNT - 1);

    state_t          state;
    logic [CW-1:0]   match_cnt;
    logic [CW-1:0]   miss_cnt;
    logic [PW-1:0]   cand_q;
    logic            strb_mode_q;
    logic            match;
    logic [PW-1:0]   cand_phase;
    logic            force_search;
    logic [PW:0]     shift_amt;

    adrv9001_strb_phase_detect #(
        .WIDTH (WIDTH)
    ) u_detect (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .strb_mode  (strb_mode),
        .strb_in    (strb_in),
        .match      (match),
        .cand_phase (cand_phase)
    );

    // A mode change invalidates any phase found under the old pattern
    assign force_search = resync | (strb_mode != strb_mode_q);

    // Lock qualification: SEARCH -> VERIFY -> LOCKED, forced restart wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEARCH;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            cand_q      <= '0;
            phase       <= '0;
            locked      <= 1'b0;
            lock_lost   <= 1'b0;
            strb_mode_q <= STRB_PULSE;
        end else begin
            lock_lost   <= 1'b0;
            strb_mode_q <= strb_mode;
            if (force_search) begin
                state     <= SEARCH;
                match_cnt <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b0;
                lock_lost <= (state == LOCKED);
            end else if (valid_in) begin
                case (state)
                    SEARCH: begin
                        if (match) begin
                            cand_q    <= cand_phase;
                            match_cnt <= CW'(1);
                            if (LOCK_COUNT == 1) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                phase    <= cand_phase;
                                miss_cnt <= '0;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (match && (cand_phase == cand_q)) begin
                            if (match_cnt != CNT_MAX) begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                            if (match_cnt == LOCK_LAST) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                phase    <= cand_q;
                                miss_cnt <= '0;
                            end
                        end else if (match) begin
                            cand_q    <= cand_phase;
                            match_cnt <= CW'(1);
                        end else begin
                            state     <= SEARCH;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (match && (cand_phase == phase)) begin
                            miss_cnt <= '0;
                        end else if (miss_cnt == UNLOCK_LAST) begin
                            state     <= SEARCH;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                        end else if (miss_cnt != CNT_MAX) begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= SEARCH;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Phase p selects window bits [2W-1-p : W-p], i.e. a right shift by W-p
    assign shift_amt = (PW+1)'(WIDTH) - {1'b0, phase};

    // Output valid is gated by the lock state at capture time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in & locked;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        logic [WIDTH-1:0]   hold;
        logic [2*WIDTH-1:0] window;
        logic [WIDTH-1:0]   aligned;

        assign window  = {hold, data_in[n*WIDTH +: WIDTH]};
        assign aligned = WIDTH'(window >> shift_amt);

        // Lane hold and aligned output, both advanced only by valid words
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold                        <= '0;
                data_out[n*WIDTH +: WIDTH]  <= '0;
            end else if (valid_in) begin
                hold                        <= data_in[n*WIDTH +: WIDTH];
                data_out[n*WIDTH +: WIDTH]  <= aligned;
            end
        end
    end

endmodule
